dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (1-cycle read latency; active-low ceb/web) between two requesters. The pipeline MEM-stage port has priority. A secondary requester (context-save unit / debug / DMA) uses a valid/ready handshake through a 1-entry request buffer. A starvation counter bounds the secondary's wait by briefly stalling the pipeline. The block sits between the MEM stage and the dmemory instance.

Parameters:
ADDR_W, 10, word-address width of dmemory
STARVE_MAX, 4, consecutive denied cycles before the secondary is force-granted (1..15)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cpu_ceb_i  in  1  pipeline chip enable, active-low (already high on trap flush)
cpu_web_i  in  1  pipeline write enable, active-low (1 = read)
cpu_addr_i  in  ADDR_W  pipeline word address
cpu_mask_i  in  4  pipeline byte enables
cpu_wdata_i  in  32  pipeline store data
cpu_rdata_o  out  32  read data for the pipeline, valid 1 cycle after a granted CPU read
cpu_stall_o  out  1  CPU access not performed this cycle; hold it and reissue
sec_req_valid_i  in  1  secondary request valid
sec_req_ready_o  out  1  request buffer can accept
sec_we_i  in  1  secondary write (1) / read (0)
sec_addr_i  in  ADDR_W  secondary word address
sec_mask_i  in  4  secondary byte enables
sec_wdata_i  in  32  secondary write data
sec_rsp_valid_o  out  1  one-cycle completion pulse
sec_rdata_o  out  32  read data, qualified by sec_rsp_valid_o
mem_ceb_o  out  1  to dmemory ceb
mem_web_o  out  1  to dmemory web
mem_a_o  out  ADDR_W  to dmemory A
mem_mask_o  out  4  to dmemory mask
mem_d_o  out  32  to dmemory D
mem_q_i  in  32  from dmemory Q

Behaviour:
- Reset (async, resetn=0): buffer empty, starve_cnt=0, rd_owner=NONE, sec_rsp_valid_o=0, sec_rdata_o=0, cpu_stall_o=0. Memory outputs go idle: mem_ceb_o=1, mem_web_o=1, address, mask and data all 0.
- Request buffer (1 entry):
  - sec_req_ready_o = ~buf_full.
  - Accept on valid&ready.
  - If the buffer is freed (granted) in the same cycle, ready stays 0. No bypass: the earliest grant is the cycle after acceptance.
- Grant per cycle (combinational):
  - force = buf_full & (starve_cnt == STARVE_MAX).
  - cpu_req = ~cpu_ceb_i.
  - If force: SEC is granted and cpu_stall_o = cpu_req.
  - Else if cpu_req: CPU is granted and cpu_stall_o = 0.
  - Else if buf_full: SEC is granted.
  - Else: the memory is idle.
- The granted requester's fields drive mem_* directly.
  - A secondary write drives mem_web_o=0.
  - A secondary read drives mem_web_o=1, mask 0, data 0.
  - When idle, memory outputs take their reset values.
- starve_cnt:
  - Resets to 0 when SEC is granted or the buffer is empty.
  - Increments (saturating at STARVE_MAX) each cycle buf_full and CPU is granted.
  - After a forced grant the count restarts. The stalled CPU reissues next cycle and wins.
- Read return (rd_owner flop records the grant type: CPU_RD, SEC_RD, SEC_WR, NONE):
  - cpu_rdata_o = mem_q_i when rd_owner==CPU_RD, else 0 (combinational).
  - sec_rsp_valid_o = 1 the cycle after a SEC grant, for both reads and writes.
  - sec_rdata_o = mem_q_i for SEC_RD, 0 for SEC_WR.
  - The buffer clears on the grant cycle, so back-to-back secondary throughput is 1 per 2 cycles.
- A CPU access while the buffer is empty is never stalled.
- Simultaneous sec accept and CPU request: the CPU is granted and the buffer fills.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds outputs arb_conflict_cnt_o[31:0] and arb_stall_cnt_o[31:0], both saturating and reset to 0.
  - Conflict counter: increments each cycle buf_full & cpu_req.
  - Stall counter: increments each cycle cpu_stall_o=1.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/definitions header: rd_owner encoding (NONE=0, CPU_RD=1, SEC_RD=2, SEC_WR=3) and the idle memory-command constants.
- One natural sub-module: dmem_arb_reqbuf, the 1-entry valid/ready buffer holding we/addr/mask/wdata.

Test Plan:
1. CPU read at addr 0x010 with the buffer empty -> mem_ceb_o=0, mem_web_o=1, mem_a_o=0x010 the same cycle. cpu_rdata_o = mem_q_i next cycle. cpu_stall_o stays 0.
2. Idle CPU; secondary write to addr 0x020, mask 4'b1111, data 0xDEADBEEF -> accepted in cycle 0, mem write in cycle 1, sec_rsp_valid_o=1 in cycle 2 with sec_rdata_o=0.
3. CPU accessing every cycle plus one secondary read (STARVE_MAX=4) -> CPU wins 4 cycles. On the 5th, SEC is granted and cpu_stall_o=1. The 6th cycle is a CPU grant, and sec_rsp_valid_o=1 with that read's data.
4. Secondary requests back-to-back with valid held high -> ready toggles 1,0,1,0, and one grant occurs every 2 cycles.
5. resetn asserted during a pending secondary read -> all outputs return to reset values immediately; no sec_rsp_valid_o after release.
6. With DMEM_ARB_PERF_EN, scenario 3 -> arb_conflict_cnt_o=5 and arb_stall_cnt_o=1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: read-return ownership encoding
// and the idle memory command driven whenever nobody owns the port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_SEC_RD = 2'd2,
        OWN_SEC_WR = 2'd3
    } rd_owner_e;

    localparam logic        IDLE_CEB  = 1'b1;
    localparam logic        IDLE_WEB  = 1'b1;
    localparam logic [3:0]  IDLE_MASK = 4'h0;
    localparam logic [31:0] IDLE_DATA = 32'h0;

endpackage

// File: rtl/dmem_arb_reqbuf.sv
// One-entry request buffer for the secondary requester; no bypass, so a held
// request is visible to the arbiter no earlier than the cycle after acceptance.
module dmem_arb_reqbuf #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_mask,
    input  logic [31:0]       i_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_mask,
    output logic [31:0]       o_wdata
);

    // Handshake: a request transfers on a rising edge where i_valid and o_ready are
    // both high; the producer keeps its fields stable while i_valid=1 and o_ready=0,
    // and o_ready never depends on i_valid.
    logic              r_full;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_mask;
    logic [31:0]       r_wdata;
    logic              w_accept;

    assign o_ready  = ~r_full;
    assign w_accept = i_valid & ~r_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_full  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_mask  <= i_mask;
            r_wdata <= i_wdata;
        end else if (i_pop) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_mask  = r_mask;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory; the MEM stage wins unless
// the secondary has starved STARVE_MAX cycles. `define DMEM_ARB_PERF_EN adds counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_ceb_i,
    input  logic              cpu_web_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_mask_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              sec_req_valid_i,
    output logic              sec_req_ready_o,
    input  logic              sec_we_i,
    input  logic [ADDR_W-1:0] sec_addr_i,
    input  logic [3:0]        sec_mask_i,
    input  logic [31:0]       sec_wdata_i,
    output logic              sec_rsp_valid_o,
    output logic [31:0]       sec_rdata_o,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       arb_conflict_cnt_o,
    output logic [31:0]       arb_stall_cnt_o,
`endif
    output logic              mem_ceb_o,
    output logic              mem_web_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [3:0]        mem_mask_o,
    output logic [31:0]       mem_d_o,
    input  logic [31:0]       mem_q_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              w_buf_full;
    logic              w_buf_we;
    logic [ADDR_W-1:0] w_buf_addr;
    logic [3:0]        w_buf_mask;
    logic [31:0]       w_buf_wdata;
    logic              w_cpu_req;
    logic              w_force;
    logic              w_grant_sec;
    logic              w_grant_cpu;
    logic [3:0]        r_starve_cnt;
    rd_owner_e         r_rd_owner;
    rd_owner_e         w_rd_owner_nxt;

    dmem_arb_reqbuf #(.ADDR_W(ADDR_W)) u_reqbuf (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (sec_req_valid_i),
        .o_ready (sec_req_ready_o),
        .i_we    (sec_we_i),
        .i_addr  (sec_addr_i),
        .i_mask  (sec_mask_i),
        .i_wdata (sec_wdata_i),
        .i_pop   (w_grant_sec),
        .o_full  (w_buf_full),
        .o_we    (w_buf_we),
        .o_addr  (w_buf_addr),
        .o_mask  (w_buf_mask),
        .o_wdata (w_buf_wdata)
    );

    assign w_cpu_req   = ~cpu_ceb_i;
    assign w_force     = w_buf_full & (r_starve_cnt == STARVE_LIM);
    assign w_grant_sec = w_force | (w_buf_full & ~w_cpu_req);
    assign w_grant_cpu = w_cpu_req & ~w_force;
    assign cpu_stall_o = w_force & w_cpu_req;

    // A secondary read presents a clean command: no mask, no data.
    always_comb begin
        mem_ceb_o      = IDLE_CEB;
        mem_web_o      = IDLE_WEB;
        mem_a_o        = '0;
        mem_mask_o     = IDLE_MASK;
        mem_d_o        = IDLE_DATA;
        w_rd_owner_nxt = OWN_NONE;
        if (w_grant_sec) begin
            mem_ceb_o      = 1'b0;
            mem_web_o      = ~w_buf_we;
            mem_a_o        = w_buf_addr;
            mem_mask_o     = w_buf_we ? w_buf_mask : IDLE_MASK;
            mem_d_o        = w_buf_we ? w_buf_wdata : IDLE_DATA;
            w_rd_owner_nxt = w_buf_we ? OWN_SEC_WR : OWN_SEC_RD;
        end else if (w_grant_cpu) begin
            mem_ceb_o      = 1'b0;
            mem_web_o      = cpu_web_i;
            mem_a_o        = cpu_addr_i;
            mem_mask_o     = cpu_mask_i;
            mem_d_o        = cpu_wdata_i;
            w_rd_owner_nxt = cpu_web_i ? OWN_CPU_RD : OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
            r_rd_owner   <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
            if (w_grant_sec || !w_buf_full) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign cpu_rdata_o     = (r_rd_owner == OWN_CPU_RD) ? mem_q_i : 32'h0;
    assign sec_rsp_valid_o = (r_rd_owner == OWN_SEC_RD) || (r_rd_owner == OWN_SEC_WR);
    assign sec_rdata_o     = (r_rd_owner == OWN_SEC_RD) ? mem_q_i : 32'h0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_buf_full && w_cpu_req && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
            if (cpu_stall_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign arb_conflict_cnt_o = r_conflict_cnt;
    assign arb_stall_cnt_o    = r_stall_cnt;
`endif

endmodule
